hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core. Generates the PC enable, the per-register enables (pipe1_en to pipe4_en for IF/DC, DC/EX, EX/MEM and MEM/WB) and the synchronous flushes (hz_flushed1 to hz_flushed3) consumed by the inter-stage registers.
- Resolves, in a fixed priority order: halt, data-memory wait, control redirect, load-use hazard, and instruction-fetch miss.
- Counts stall cycles for performance debug.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock, all state on the rising edge.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  instruction memory returned a valid word this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- mem_dreq  in  1  MEM stage holds a load or store (d_ren or d_wen of EX/MEM).
- mem_halt  in  1  halt instruction present in the MEM stage.
- mem_redirect  in  1  branch taken or jump resolved in MEM; PC is being redirected.
- ex_d_ren  in  1  instruction in EX is a load (DC/EX d_ren output).
- ex_wsel  in  5  destination register of the instruction in EX.
- dc_rsel1  in  5  rs of the instruction in DC.
- dc_rsel2  in  5  rt of the instruction in DC.
- dc_uses_rt  in  1  DC instruction reads rt as a source.
- pc_en  out  1  PC register update enable.
- pipe1_en, pipe2_en, pipe3_en, pipe4_en  out  1 each  inter-stage register enables.
- hz_flushed1, hz_flushed2, hz_flushed3  out  1 each  clear IF/DC, DC/EX, EX/MEM to the bubble value. In those registers, flush overrides enable.
- halted  out  1  registered; the core is halted.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_en=0 while not halted.

Behaviour:
- Reset is synchronous: on a CLK edge with RST=1, state goes to RUN, halted=0 and stall_cycles=0.
- While RST=1, all enables and flushes are forced to 0 combinationally.
- Enables and flushes are combinational from the state and the inputs, so the registers act in the same cycle. halted and stall_cycles are registered.
- States are RUN, DWAIT and HALT.
- Load-use hazard (lu) = ex_d_ren && ex_wsel!=0 && (ex_wsel==dc_rsel1 || (dc_uses_rt && ex_wsel==dc_rsel2)).
- In RUN, the first matching rule below applies:
  1. mem_halt: pipe4_en=1, all other enables and flushes 0. Next state HALT. halted=1 from the next cycle.
  2. mem_dreq && !dhit: all enables 0, all flushes 0 (full freeze). Next state DWAIT.
  3. mem_redirect: pc_en=1, all pipeN_en=1, hz_flushed1=hz_flushed2=hz_flushed3=1. The three younger instructions are squashed.
  4. lu: pc_en=0, pipe1_en=0, hz_flushed2=1 (bubble into EX), pipe3_en=pipe4_en=1. Exactly one stall cycle per load-use pair.
  5. !ihit: pc_en=0, hz_flushed1=1 (bubble into DC), pipe2_en=pipe3_en=pipe4_en=1.
  6. Otherwise, all enables=1 and flushes=0.
- DWAIT:
  - While !dhit: full freeze, the same as RUN rule 2.
  - On dhit: evaluate RUN rules 1 and 3 to 6 (rule 2 is satisfied) and return to RUN.
  - mem_redirect or mem_halt held in the frozen EX/MEM register is therefore applied on the dhit cycle.
  - dhit together with mem_halt goes to HALT.
- HALT: all enables and flushes 0, halted=1. The block leaves HALT only through RST.
- stall_cycles increments by 1 on each edge where state!=HALT, RST=0 and pc_en=0. It saturates at all-ones with no wrap.
- Simultaneous events follow the priority above:
  - mem_halt always wins.
  - A redirect beats a load-use hazard or fetch miss in the same cycle, because the squashed instructions make them moot.
  - A data wait beats a redirect.
- RST mid-DWAIT or in HALT returns to RUN on that edge. Any in-flight memory wait is abandoned.

Test Plan:
- Reset: hold RST=1 for 2 cycles with ihit=1 → all enables 0, halted=0, stall_cycles=0. First cycle after release with ihit=1 and no hazards → pc_en and pipe1-4_en = 1.
- Load-use: ex_d_ren=1, ex_wsel=5, dc_rsel1=5, ihit=1 → pc_en=0, pipe1_en=0, hz_flushed2=1 for one cycle. Next cycle (ex_d_ren=0) all enables=1 and stall_cycles=1. Repeat with ex_wsel=0 → no stall.
- Data wait: mem_dreq=1, dhit=0 for 3 cycles, then dhit=1 → all enables 0 for 3 cycles and state DWAIT, then all enables=1 and RUN. stall_cycles=3.
- Redirect during wait: mem_dreq=1 and mem_redirect=1, dhit low for 2 cycles then high → freeze for 2 cycles, then hz_flushed1-3=1 with pc_en=1 on the dhit cycle.
- Priority: mem_redirect=1 with the lu condition and ihit=0 → flushes 1-3 asserted, pc_en=1, no stall counted. mem_halt=1 in the same cycle → only pipe4_en=1, halted=1 next cycle and held for 10 cycles.
- Saturation: set STALL_CNT_W=4 and hold ihit=0 for 20 cycles → stall_cycles stops at 15. Assert RST → 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline sequencer: PC/stage enables, bubble flushes,
//            halt tracking and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dreq,
    input  logic                   mem_halt,
    input  logic                   mem_redirect,
    input  logic                   ex_d_ren,
    input  logic [4:0]             ex_wsel,
    input  logic [4:0]             dc_rsel1,
    input  logic [4:0]             dc_rsel2,
    input  logic                   dc_uses_rt,
    output logic                   pc_en,
    output logic                   pipe1_en,
    output logic                   pipe2_en,
    output logic                   pipe3_en,
    output logic                   pipe4_en,
    output logic                   hz_flushed1,
    output logic                   hz_flushed2,
    output logic                   hz_flushed3,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = '1;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_halted;
    logic [STALL_CNT_W-1:0]   r_stall_cycles;
    logic                     w_lu;
    logic                     w_go;
    logic                     w_halt_now;

    // Enable/flush vector: {pc, p1, p2, p3, p4, f1, f2, f3}
    logic [7:0]               w_ctl;

    always_comb begin
        w_lu = ex_d_ren && (ex_wsel != 5'd0) &&
               ((ex_wsel == dc_rsel1) || (dc_uses_rt && (ex_wsel == dc_rsel2)));
    end

    always_comb begin
        w_go       = 1'b0;
        w_halt_now = 1'b0;
        w_next     = r_state;
        case (r_state)
            RUN: begin
                if (mem_halt) begin
                    w_halt_now = 1'b1;
                    w_next     = HALT;
                end else if (mem_dreq && !dhit) begin
                    w_next = DWAIT;
                end else begin
                    w_go = 1'b1;
                end
            end
            DWAIT: begin
                // Frozen EX/MEM contents are acted on only when the access completes
                if (dhit) begin
                    if (mem_halt) begin
                        w_halt_now = 1'b1;
                        w_next     = HALT;
                    end else begin
                        w_go   = 1'b1;
                        w_next = RUN;
                    end
                end
            end
            HALT: begin
                w_next = HALT;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    always_comb begin
        w_ctl = 8'b0000_0000;
        if (!RST) begin
            if (w_halt_now) begin
                w_ctl = 8'b0000_1000;
            end else if (w_go) begin
                if (mem_redirect) begin
                    w_ctl = 8'b1111_1111;
                end else if (w_lu) begin
                    w_ctl = 8'b0001_1010;
                end else if (!ihit) begin
                    w_ctl = 8'b0011_1100;
                end else begin
                    w_ctl = 8'b1111_1000;
                end
            end
        end
    end

    assign pc_en        = w_ctl[7];
    assign pipe1_en     = w_ctl[6];
    assign pipe2_en     = w_ctl[5];
    assign pipe3_en     = w_ctl[4];
    assign pipe4_en     = w_ctl[3];
    assign hz_flushed1  = w_ctl[2];
    assign hz_flushed2  = w_ctl[1];
    assign hz_flushed3  = w_ctl[0];
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= RUN;
            r_halted       <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALT);
            if ((r_state != HALT) && !pc_en && (r_stall_cycles != c_STALL_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
